sdram_bridge: RTL and testbench

Adapts the 32-bit CPU memory bus (valid/ready, byte strobes) to the 16-bit single-access SDRAM controller directly downstream. Splits each 32-bit access into up to two 16-bit SDRAM accesses (little-endian, low half first). Performs read-modify-write for partial-halfword stores, since the controller always writes both bytes (DM=00). Sits between the SoC bus arbiter and the SDRAM controller.

---
 rtl/sdram_bridge_pkg.sv | 40 ++++
 rtl/sdram_bridge_rbuf.sv | 36 +++
 rtl/sdram_bridge.sv | 164 ++++++++++++++++
 tb/tb_sdram_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bridge_pkg.sv
// rtl/sdram_bridge_pkg.sv - shared types, widths and halfword helpers for sdram_bridge
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    STEP_READ,
    STEP_WRITE,
    STEP_RMW,
    STEP_SKIP
  } step_t;

  localparam int SD_ADDR_W = 32;

  function automatic step_t plan_half(input logic is_read, input logic [1:0] strb);
    if (is_read)
      return STEP_READ;
    else if (strb == 2'b11)
      return STEP_WRITE;
    else if (strb == 2'b00)
      return STEP_SKIP;
    else
      return STEP_RMW;
  endfunction

  // New bytes where the strobe is set, old SDRAM bytes elsewhere.
  function automatic logic [15:0] merge_half(input logic [15:0] old_data,
                                             input logic [15:0] new_data,
                                             input logic [1:0]  strb);
    return {strb[1] ? new_data[15:8] : old_data[15:8],
            strb[0] ? new_data[7:0]  : old_data[7:0]};
  endfunction

endpackage

// File: rtl/sdram_bridge_rbuf.sv
// rtl/sdram_bridge_rbuf.sv - one-entry word read buffer with tag match and write invalidate
module sdram_bridge_rbuf #(
  parameter int TAG_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [31:0]      data,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             inval_en,
  input  logic [TAG_W-1:0] inval_tag
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  assign hit = valid && (tag == lookup_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (inval_en && valid && (tag == inval_tag)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_bridge.sv
// rtl/sdram_bridge.sv - 32-bit CPU bus to 16-bit SDRAM controller bridge with halfword RMW
// Optional one-entry read buffer enabled by defining SDRAM_BRIDGE_RBUF_EN.
module sdram_bridge
  import sdram_pkg::*;
#(
  parameter int ADDR_BITS = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic [SD_ADDR_W-1:0] sd_addr,
  output logic [15:0]          sd_wdata,
  output logic                 sd_wstrb,
  output logic                 sd_rstrb,
  input  logic [15:0]          sd_rdata,
  input  logic                 sd_ready
);

  localparam int WORD_W = ADDR_BITS - 2;

  state_t              state;
  step_t               plan_lo, plan_hi;
  logic                half, phase, is_read_q;
  logic [WORD_W-1:0]   word;
  logic [31:0]         wdata_q, rd_q;
  logic [3:0]          wstrb_q;
  logic [15:0]         merge_q;

  logic                unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

  logic              req_read;
  logic [WORD_W-1:0] req_word;
  step_t             new_lo, new_hi, cur_step;
  logic [15:0]       cur_wdata;
  logic [1:0]        cur_strb;
  logic              rd_step, more;

  assign req_read  = (mem_wstrb == 4'b0000);
  assign req_word  = mem_addr[ADDR_BITS-1:2];
  assign new_lo    = plan_half(req_read, mem_wstrb[1:0]);
  assign new_hi    = plan_half(req_read, mem_wstrb[3:2]);
  assign cur_step  = half ? plan_hi : plan_lo;
  assign cur_wdata = half ? wdata_q[31:16] : wdata_q[15:0];
  assign cur_strb  = half ? wstrb_q[3:2] : wstrb_q[1:0];
  assign rd_step   = (cur_step == STEP_READ) || ((cur_step == STEP_RMW) && !phase);
  // Another step follows: the write half of an RMW, or a non-skipped high half.
  assign more      = ((cur_step == STEP_RMW) && !phase) || (!half && (plan_hi != STEP_SKIP));

  logic        rbuf_hit;
  logic [31:0] rbuf_data;

`ifdef SDRAM_BRIDGE_RBUF_EN
  logic fill_en, inval_en;
  assign fill_en  = (state == ST_GAP) && !more && is_read_q;
  assign inval_en = (state == ST_IDLE) && mem_valid && !req_read;

  sdram_bridge_rbuf #(
    .TAG_W(WORD_W)
  ) u_rbuf (
    .clk        (clk),
    .reset      (reset),
    .lookup_tag (req_word),
    .hit        (rbuf_hit),
    .data       (rbuf_data),
    .fill_en    (fill_en),
    .fill_tag   (word),
    .fill_data  (rd_q),
    .inval_en   (inval_en),
    .inval_tag  (req_word)
  );
`else
  assign rbuf_hit  = 1'b0;
  assign rbuf_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      plan_lo   <= STEP_SKIP;
      plan_hi   <= STEP_SKIP;
      half      <= 1'b0;
      phase     <= 1'b0;
      is_read_q <= 1'b0;
      word      <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      merge_q   <= '0;
      rd_q      <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      sd_addr   <= '0;
      sd_wdata  <= '0;
      sd_wstrb  <= 1'b0;
      sd_rstrb  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_valid) begin
            word      <= req_word;
            wdata_q   <= mem_wdata;
            wstrb_q   <= mem_wstrb;
            is_read_q <= req_read;
            if (req_read && rbuf_hit) begin
              mem_rdata <= rbuf_data;
              mem_ready <= 1'b1;
              state     <= ST_DONE;
            end else begin
              plan_lo <= new_lo;
              plan_hi <= new_hi;
              half    <= (new_lo == STEP_SKIP);
              phase   <= 1'b0;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          sd_addr  <= SD_ADDR_W'({word, half});
          sd_wdata <= (cur_step == STEP_RMW) ? merge_half(merge_q, cur_wdata, cur_strb)
                                             : cur_wdata;
          sd_rstrb <= rd_step;
          sd_wstrb <= !rd_step;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sd_ready) begin
            sd_rstrb <= 1'b0;
            sd_wstrb <= 1'b0;
            if (cur_step == STEP_READ) begin
              if (half) rd_q[31:16] <= sd_rdata;
              else      rd_q[15:0]  <= sd_rdata;
            end else if (cur_step == STEP_RMW && !phase) begin
              merge_q <= sd_rdata;
            end
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if ((cur_step == STEP_RMW) && !phase) begin
            phase <= 1'b1;
            state <= ST_ISSUE;
          end else if (!half && (plan_hi != STEP_SKIP)) begin
            half  <= 1'b1;
            phase <= 1'b0;
            state <= ST_ISSUE;
          end else begin
            mem_ready <= 1'b1;
            if (is_read_q) mem_rdata <= rd_q;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bridge.sv
// tb/tb_sdram_bridge.sv - scoreboard bench for sdram_bridge with a negedge SDRAM controller model
module tb_sdram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] sd_addr;
  logic [15:0] sd_wdata;
  logic        sd_wstrb, sd_rstrb;
  logic [15:0] sd_rdata;
  logic        sd_ready;

  sdram_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sd_addr   (sd_addr),
    .sd_wdata  (sd_wdata),
    .sd_wstrb  (sd_wstrb),
    .sd_rstrb  (sd_rstrb),
    .sd_rdata  (sd_rdata),
    .sd_ready  (sd_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_rd[$];
  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic wr, input logic [31:0] addr, input logic [15:0] data);
    acc_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    exp_acc.push_back(e);
  endtask

  // Controller model: samples strobes on negedge, done pulse two negedges after the start.
  bit          busy = 0;
  int          cnt;
  logic        op_wr;
  logic [31:0] op_addr;
  logic [15:0] op_data;

  always @(negedge clk) begin
    sd_ready = 1'b0;
    if (busy) begin
      if (cnt == 0) begin
        if (op_wr) mem[op_addr[7:0]] = op_data;
        else       sd_rdata = mem[op_addr[7:0]];
        sd_ready = 1'b1;
        busy     = 0;
      end else begin
        cnt--;
      end
    end else if (sd_rstrb || sd_wstrb) begin
      busy = 1; cnt = 1;
      op_wr = sd_wstrb; op_addr = sd_addr; op_data = sd_wdata;
      checks++;
      if (sd_rstrb && sd_wstrb) begin
        errors++;
        $display("FAIL strobes_both actual=11 expected=one");
      end else if (exp_acc.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access actual wr=%0d addr=%h data=%h expected=none", op_wr, op_addr, op_data);
      end else begin
        acc_t e;
        e = exp_acc.pop_front();
        if (e.wr !== op_wr || e.addr !== op_addr || (e.wr && e.data !== op_data)) begin
          errors++;
          $display("FAIL access actual wr=%0d addr=%h data=%h expected wr=%0d addr=%h data=%h",
                   op_wr, op_addr, op_data, e.wr, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_ready) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_ready actual=1 expected=0 rdata=%h", mem_rdata);
      end else begin
        logic [31:0] e;
        e = exp_rd.pop_front();
        if (mem_rdata !== e) begin
          errors++;
          $display("FAIL mem_rdata actual=%h expected=%h", mem_rdata, e);
        end
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int exp_lat);
    int n;
    bit got;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (mem_ready) got = 1;
    end
    mem_valid = 1'b0; mem_wstrb = 4'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout addr=%h actual=no_ready expected=mem_ready", a);
    end else if (n != exp_lat) begin
      errors++;
      $display("FAIL latency addr=%h actual=%0d expected=%0d", a, n, exp_lat);
    end
  endtask

  initial begin
    bit stray;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    sd_ready = 1'b0; sd_rdata = 16'h0;
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("reset_mem_ready", {31'b0, mem_ready}, 32'h0);
    chk("reset_mem_rdata", mem_rdata, 32'h0);
    chk("reset_sd_addr", sd_addr, 32'h0);
    chk("reset_strobes", {30'b0, sd_wstrb, sd_rstrb}, 32'h0);
    chk("reset_sd_wdata", {16'b0, sd_wdata}, 32'h0);
    reset = 1'b0;

    // Full-word read, low half first.
    mem[8'h82] = 16'h1234; mem[8'h83] = 16'hABCD;
    push_acc(0, 32'h82, 0); push_acc(0, 32'h83, 0); exp_rd.push_back(32'hABCD_1234);
    access(32'h0000_0104, 32'h0, 4'b0000, 11);

    // Address bits above ADDR_BITS are ignored.
`ifdef SDRAM_BRIDGE_RBUF_EN
    exp_rd.push_back(32'hABCD_1234);
    access(32'hFE00_0104, 32'h0, 4'b0000, 1);
`else
    push_acc(0, 32'h82, 0); push_acc(0, 32'h83, 0); exp_rd.push_back(32'hABCD_1234);
    access(32'hFE00_0104, 32'h0, 4'b0000, 11);
`endif

    // Full-word write, no reads.
    push_acc(1, 32'h8, 16'hBEEF); push_acc(1, 32'h9, 16'hDEAD); exp_rd.push_back(32'hABCD_1234);
    access(32'h10, 32'hDEAD_BEEF, 4'b1111, 11);
    chk("mem8_full", {16'b0, mem[8]}, 32'hBEEF);
    chk("mem9_full", {16'b0, mem[9]}, 32'hDEAD);

    // Low-byte RMW, high half skipped.
    mem[8] = 16'h1122;
    push_acc(0, 32'h8, 0); push_acc(1, 32'h8, 16'h11AA); exp_rd.push_back(32'hABCD_1234);
    access(32'h10, 32'h0000_00AA, 4'b0001, 11);
    chk("mem8_rmw_lo", {16'b0, mem[8]}, 32'h11AA);
    chk("mem9_untouched", {16'b0, mem[9]}, 32'hDEAD);

    // High half only, full-halfword write.
    push_acc(1, 32'h9, 16'h5566); exp_rd.push_back(32'hABCD_1234);
    access(32'h10, 32'h5566_0000, 4'b1100, 6);
    chk("mem8_skip", {16'b0, mem[8]}, 32'h11AA);
    chk("mem9_hi_write", {16'b0, mem[9]}, 32'h5566);

    // High-byte RMW in the high half.
    push_acc(0, 32'h9, 0); push_acc(1, 32'h9, 16'h7766); exp_rd.push_back(32'hABCD_1234);
    access(32'h10, 32'h7700_0000, 4'b1000, 11);
    chk("mem9_rmw_hi", {16'b0, mem[9]}, 32'h7766);

    push_acc(0, 32'h8, 0); push_acc(0, 32'h9, 0); exp_rd.push_back(32'h7766_11AA);
    access(32'h10, 32'h0, 4'b0000, 11);

    // Reset while the first write step waits on the controller.
    push_acc(1, 32'h18, 16'hBEEF);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b1111;
    begin
      int n;
      n = 0;
      while (n < 20 && !sd_wstrb) begin @(negedge clk); n++; end
      chk("reset_test_strobe_seen", {31'b0, sd_wstrb}, 32'h1);
    end
    reset = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'b0;
    @(negedge clk);
    chk("reset_mid_strobes", {30'b0, sd_wstrb, sd_rstrb}, 32'h0);
    reset = 1'b0;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (sd_wstrb || sd_rstrb) stray = 1;
    end
    chk("reset_mid_no_retry", {31'b0, stray}, 32'h0);
    chk("reset_mid_rdata", mem_rdata, 32'h0);

    // Read buffer behaviour (without the buffer every read goes to SDRAM).
    mem[8'h10] = 16'h0101; mem[8'h11] = 16'h0202;
    push_acc(0, 32'h10, 0); push_acc(0, 32'h11, 0); exp_rd.push_back(32'h0202_0101);
    access(32'h20, 32'h0, 4'b0000, 11);
`ifdef SDRAM_BRIDGE_RBUF_EN
    exp_rd.push_back(32'h0202_0101);
    access(32'h20, 32'h0, 4'b0000, 1);
`else
    push_acc(0, 32'h10, 0); push_acc(0, 32'h11, 0); exp_rd.push_back(32'h0202_0101);
    access(32'h20, 32'h0, 4'b0000, 11);
`endif
    push_acc(1, 32'h10, 16'hF00D); push_acc(1, 32'h11, 16'hCAFE); exp_rd.push_back(32'h0202_0101);
    access(32'h20, 32'hCAFE_F00D, 4'b1111, 11);
    push_acc(0, 32'h10, 0); push_acc(0, 32'h11, 0); exp_rd.push_back(32'hCAFE_F00D);
    access(32'h20, 32'h0, 4'b0000, 11);

    repeat (5) @(negedge clk);
    chk("acc_queue_empty", exp_acc.size(), 32'h0);
    chk("rd_queue_empty", exp_rd.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
